// File: rtl/bin2bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
// Holds the FSM state encoding, the default magnitude width and digit count,
// and a helper for the shift-counter width.
package bin2bcd_seq_pkg;

  localparam int W_DEF  = 9;
  localparam int ND_DEF = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Counter must hold the value w (loaded at start), hence w+1 codes.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/bin2bcd_seq_bcd_add3.sv
// Double-dabble digit correction cell.
// Ports:
//   din  - 4-bit BCD digit before the shift
//   dout - din + 3 when din >= 5, otherwise din (4-bit, carry dropped)
module bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  always_comb begin
    dout = din;
    if (din >= 4'd5) dout = din + 4'd3;
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// A conversion is started with a one-cycle start request in IDLE and framed
// by a one-cycle done pulse W cycles later.
// Ports:
//   clk   - system clock, rising edge
//   rst   - asynchronous active-high reset, clears all state and outputs
//   start - conversion request, sampled only in IDLE
//   in    - unsigned W-bit magnitude, captured on the accepting edge
//   neg   - sign of the original value, captured with in
//   busy  - high while a conversion is running
//   done  - registered one-cycle pulse when bcd/sign are updated
//   sign  - registered copy of the captured neg
//   bcd   - ND BCD digits, most significant nibble first, held between runs
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int ND = ND_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [W-1:0]    in,
  input  logic            neg,
  output logic            busy,
  output logic            done,
  output logic            sign,
  output logic [4*ND-1:0] bcd
);

  localparam int RW = 4 * ND + W;
  localparam int CW = cnt_width(W);

  state_t          state, state_nxt;
  logic [RW-1:0]   sr, sr_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            neg_lat, neg_lat_nxt;
  logic            done_nxt;
  logic            sign_nxt;
  logic [4*ND-1:0] bcd_nxt;
  logic [4*ND-1:0] adj;
  logic [RW-1:0]   shifted;

  // One correction cell per digit; the digits sit above the binary part.
  for (genvar g = 0; g < ND; g++) begin : g_add3
    bcd_add3 u_add3 (
      .din  (sr[W + 4*g +: 4]),
      .dout (adj[4*g +: 4])
    );
  end

  assign shifted = {adj, sr[W-1:0]} << 1;
  assign busy    = (state == SHIFT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      sr      <= '0;
      cnt     <= '0;
      neg_lat <= 1'b0;
      done    <= 1'b0;
      sign    <= 1'b0;
      bcd     <= '0;
    end else begin
      state   <= state_nxt;
      sr      <= sr_nxt;
      cnt     <= cnt_nxt;
      neg_lat <= neg_lat_nxt;
      done    <= done_nxt;
      sign    <= sign_nxt;
      bcd     <= bcd_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    sr_nxt      = sr;
    cnt_nxt     = cnt;
    neg_lat_nxt = neg_lat;
    done_nxt    = 1'b0;
    sign_nxt    = sign;
    bcd_nxt     = bcd;
    unique case (state)
      IDLE: begin
        if (start) begin
          sr_nxt      = {{(4*ND){1'b0}}, in};
          neg_lat_nxt = neg;
          cnt_nxt     = CW'(W);
          state_nxt   = SHIFT;
        end
      end
      SHIFT: begin
        sr_nxt  = shifted;
        cnt_nxt = cnt - 1'b1;
        // Last shift: publish the freshly shifted digits on the same edge.
        if (cnt == CW'(1)) begin
          bcd_nxt   = shifted[RW-1 -: 4*ND];
          sign_nxt  = neg_lat;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential binary-to-BCD converter that consumes the 9-bit magnitude produced by the two's-complement stage and turns it into three decimal digits for the display path. It uses the shift-and-add-3 (double-dabble) method, one bit per clock. A one-cycle START/DONE handshake frames each conversion. A sign flag travels with the value, so the display stage can draw a minus sign.

## Interface
- W, 9: input magnitude width in bits.
- ND, 3: BCD digits produced. Must satisfy 10^ND > 2^W − 1.
- CLK  input  1  system clock; all state changes on the rising edge.
- RST  input  1  asynchronous reset, active-high. Clears all state and outputs.
- START  input  1  conversion request. Sampled only in IDLE.
- IN  input  W  unsigned magnitude, captured on the edge that accepts START.
- NEG  input  1  sign of the original value, captured together with IN.
- BUSY  output  1  high while a conversion is running (SHIFT state).
- DONE  output  1  one-cycle pulse when BCD and SIGN are updated.
- SIGN  output  1  registered copy of the captured NEG.
- BCD  output  4*ND  digits, most significant nibble = hundreds; held between conversions.

## Operation
- States:
  - IDLE: START=1 → load the shift register with {ND×4'b0, IN}, latch NEG, set counter=W, go to SHIFT.
  - SHIFT: each cycle, every digit ≥5 gets +3 (4-bit result, no carry out). The whole {digits, bin} register then shifts left one bit and the counter decrements.
    - When the counter reaches 1, the final shift is performed.
    - On that same edge: write the post-shift digits to BCD, write the latched sign to SIGN, set DONE=1, return to IDLE.
- DONE is registered. It is high for exactly one cycle, then clears.
- START while in SHIFT is ignored. There is no queueing and no error flag.
- START=1 held continuously produces back-to-back conversions. Each new one is accepted on the first IDLE edge.
- IN and NEG are only read on the accepting edge. They may change at any other time.
- Arithmetic: internal register width is 4*ND + W. Inputs up to 2^W − 1 (511) never overflow the hundreds digit; the maximum result is 5.
- SIGN is passed through as given. NEG=1 with IN=0 outputs SIGN=1 with all digits 0; suppressing "−0" is the display stage's job.
- Reset values: state IDLE, BUSY=0, DONE=0, SIGN=0, BCD=0, counter=0.
- Reset during SHIFT aborts the conversion:
  - No DONE is produced.
  - The previous BCD is lost and cleared to 0.

## Timing
- Edge 0: START accepted; BUSY=1 from this edge.
- Edges 1..W: one shift per edge.
- Edge W: BCD and SIGN valid, DONE=1, BUSY=0.
- Edge W+1: DONE=0; a new START can be accepted on this edge.
- Latency from the accepting edge to DONE: W cycles (9 by default).
- Throughput: one conversion per W+1 cycles.
- Combinational path: ND parallel add-3 units plus a 1-bit shift. No path from inputs to outputs.

## Structure
- Shared package holds:
  - State encoding: IDLE=1'b0, SHIFT=1'b1.
  - Constants W_DEF=9 and ND_DEF=3.
  - Counter width $clog2(W+1).
- Sub-module bcd_add3: combinational, 4-bit in/out, adds 3 when the input is ≥5. Instantiated ND times through generate.
- Top level holds the FSM, counter, shift register and output registers.

## Test plan
- IN=255, NEG=0, START pulse → DONE exactly 9 cycles after the accepting edge; BCD=0x255, SIGN=0; BUSY high for 9 cycles.
- IN=511 then IN=0 (two separate conversions) → BCD=0x511, then BCD=0x000; DONE pulses are one cycle wide.
- IN=128, NEG=1 (from −128) → BCD=0x128, SIGN=1. A following IN=5, NEG=0 gives BCD=0x005, SIGN=0.
- START re-asserted with IN=99 at cycles 3 and 6 of a running IN=200 conversion → only BCD=0x200 is produced, single DONE.
- START held high with IN=37 → DONE every 10 cycles; BCD stays 0x037.
- RST asserted at cycle 4 of an IN=300 conversion, asynchronously between edges → BUSY, DONE, BCD, SIGN go to 0 immediately; no DONE follows. After release, START with IN=42 gives BCD=0x042.
